// File: rtl/adc_pkg.sv
// Shared constants for the ADC acquisition path: sample width, default
// averaging window and the clear values of the running min/max trackers.
package adc_pkg;

  localparam int ADC_DATA_W       = 16;
  localparam int DEFAULT_AVG_LOG2 = 4;

  // Min starts at all-ones and max at zero so the first sample always replaces both.
  localparam logic [ADC_DATA_W-1:0] ADC_MIN_INIT = '1;
  localparam logic [ADC_DATA_W-1:0] ADC_MAX_INIT = '0;

endpackage

// File: rtl/adc_win_avg_if.sv
// Result bus from the window averager to the packetiser/host side:
// valid/ready handshake, the three statistics and the sticky overrun flag.
interface adc_win_avg_if
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) ();

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] avg_data;
  logic [DATA_W-1:0] min_data;
  logic [DATA_W-1:0] max_data;
  logic              overrun;

  modport master (
    output out_valid,
    output avg_data,
    output min_data,
    output max_data,
    output overrun,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  avg_data,
    input  min_data,
    input  max_data,
    input  overrun,
    output out_ready
  );

endinterface

// File: rtl/adc_win_stats.sv
// Window statistics datapath: running sum, min and max, with combinational
// "result including the current sample" outputs used at window completion.
module adc_win_stats
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = DEFAULT_AVG_LOG2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_add,
  input  logic [DATA_W-1:0] i_sample,
  output logic [DATA_W-1:0] o_avg,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max
);

  // AVG_LOG2 extra bits hold a full window of full-scale samples without wrap.
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam logic [DATA_W-1:0] MIN_INIT = DATA_W'(ADC_MIN_INIT);
  localparam logic [DATA_W-1:0] MAX_INIT = DATA_W'(ADC_MAX_INIT);

  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;
  logic [ACC_W-1:0]  w_sum;

  assign w_sum = r_acc + ACC_W'(i_sample);
  assign o_avg = w_sum[ACC_W-1:AVG_LOG2];
  assign o_min = (i_sample < r_min) ? i_sample : r_min;
  assign o_max = (i_sample > r_max) ? i_sample : r_max;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_min <= MIN_INIT;
      r_max <= MAX_INIT;
    end else if (i_clr) begin
      r_acc <= '0;
      r_min <= MIN_INIT;
      r_max <= MAX_INIT;
    end else if (i_add) begin
      r_acc <= w_sum;
      r_min <= o_min;
      r_max <= o_max;
    end
  end

endmodule

// File: rtl/adc_win_avg.sv
// Captures one ADC sample per CS frame, reduces each 2^AVG_LOG2-sample window
// to average/min/max and hands the result out over a valid/ready bus.
module adc_win_avg
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = DEFAULT_AVG_LOG2
) (
  input  logic              clk_100,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cs_in,
  input  logic              en_in,
  input  logic [DATA_W-1:0] adc_data,
  adc_win_avg_if.master     res
);

  logic                r_cs_d;
  logic [AVG_LOG2-1:0] r_win_cnt;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_avg;
  logic [DATA_W-1:0]   r_min;
  logic [DATA_W-1:0]   r_max;
  logic                r_overrun;

  logic                w_smp;
  logic                w_last;
  logic                w_done;
  logic                w_accept;
  logic                w_clr;
  logic                w_add;
  logic [DATA_W-1:0]   w_nxt_avg;
  logic [DATA_W-1:0]   w_nxt_min;
  logic [DATA_W-1:0]   w_nxt_max;

  // cs_d follows cs_in unconditionally, so a CS rise seen while disabled never fires later.
  assign w_smp    = start & en_in & cs_in & ~r_cs_d;
  assign w_last   = &r_win_cnt;
  assign w_done   = w_smp & w_last;
  assign w_accept = r_out_valid & res.out_ready;
  assign w_clr    = ~start | w_done;
  assign w_add    = w_smp & ~w_last;

  adc_win_stats #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_stats (
    .i_clk    (clk_100),
    .i_rst_n  (reset_n),
    .i_clr    (w_clr),
    .i_add    (w_add),
    .i_sample (adc_data),
    .o_avg    (w_nxt_avg),
    .o_min    (w_nxt_min),
    .o_max    (w_nxt_max)
  );

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_d      <= 1'b0;
      r_win_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_avg       <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_cs_d <= cs_in;
      if (!start) begin
        r_win_cnt   <= '0;
        r_out_valid <= 1'b0;
        r_avg       <= '0;
        r_min       <= '0;
        r_max       <= '0;
        r_overrun   <= 1'b0;
      end else begin
        if (w_smp) begin
          r_win_cnt <= r_win_cnt + AVG_LOG2'(1);
        end
        // A finished window may replace a result that is being accepted this very cycle.
        if (w_done && (!r_out_valid || w_accept)) begin
          r_out_valid <= 1'b1;
          r_avg       <= w_nxt_avg;
          r_min       <= w_nxt_min;
          r_max       <= w_nxt_max;
        end else if (w_done) begin
          r_overrun <= 1'b1;
        end else if (w_accept) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign res.out_valid = r_out_valid;
  assign res.avg_data  = r_avg;
  assign res.min_data  = r_min;
  assign res.max_data  = r_max;
  assign res.overrun   = r_overrun;

endmodule

// File: tb/tb_adc_win_avg.sv
// Randomised/directed bench for adc_win_avg: a window-level reference model
// feeds a result queue that an independent monitor checks on every accept.
module tb_adc_win_avg;

  localparam int DW  = 16;
  localparam int AL  = 4;
  localparam int WIN = 1 << AL;

  logic          clk_100   = 1'b0;
  logic          reset_n   = 1'b1;
  logic          start     = 1'b0;
  logic          cs_in     = 1'b0;
  logic          en_in     = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] adc_data  = '0;
  bit            rand_rdy  = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  adc_win_avg_if #(.DATA_W(DW)) res_if ();
  assign res_if.out_ready = out_ready;

  adc_win_avg #(
    .DATA_W   (DW),
    .AVG_LOG2 (AL)
  ) dut (
    .clk_100  (clk_100),
    .reset_n  (reset_n),
    .start    (start),
    .cs_in    (cs_in),
    .en_in    (en_in),
    .adc_data (adc_data),
    .res      (res_if)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    int unsigned avg;
    int unsigned mn;
    int unsigned mx;
  } res_t;

  res_t        exp_q[$];
  int unsigned m_win[$];
  bit          m_valid = 1'b0;
  bit          m_ovr   = 1'b0;
  bit          m_cs_d  = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the samples of a window, reduces them with plain arithmetic.
  always @(posedge clk_100 or negedge reset_n) begin
    bit          smp;
    res_t        r;
    int unsigned sum;
    if (!reset_n) begin
      m_win.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_cs_d  = 1'b0;
    end else begin
      smp    = start && en_in && cs_in && !m_cs_d;
      m_cs_d = cs_in;
      if (!start) begin
        m_win.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (smp) begin
          m_win.push_back(adc_data);
          if (m_win.size() == WIN) begin
            sum  = 0;
            r.mn = 32'hFFFF;
            r.mx = 0;
            foreach (m_win[k]) begin
              sum += m_win[k];
              if (m_win[k] < r.mn) r.mn = m_win[k];
              if (m_win[k] > r.mx) r.mx = m_win[k];
            end
            r.avg = sum / WIN;
            if (!m_valid) begin
              exp_q.push_back(r);
              m_valid = 1'b1;
            end else begin
              m_ovr = 1'b1;
            end
            m_win.delete();
          end
        end
      end
    end
  end

  // Monitor: handshake state every cycle, result contents on every accept.
  always begin
    res_t r;
    @(negedge clk_100);
    #3;
    chk("out_valid", res_if.out_valid, m_valid);
    chk("overrun", res_if.overrun, m_ovr);
    if (res_if.out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL accept: result taken at %0t but none expected (avg 0x%0h)", $time, res_if.avg_data);
      end else begin
        r = exp_q.pop_front();
        chk("avg_data", res_if.avg_data, r.avg);
        chk("min_data", res_if.min_data, r.mn);
        chk("max_data", res_if.max_data, r.mx);
        $display("accept avg=0x%0h min=0x%0h max=0x%0h ovr=%0b", res_if.avg_data, res_if.min_data,
                 res_if.max_data, res_if.overrun);
      end
    end
  end

  task automatic step();
    @(negedge clk_100);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // One front-end frame: CS high for two clocks, then a random low gap.
  task automatic frame(input int unsigned v, input bit en, input bit rdy_pulse);
    step();
    adc_data = DW'(v);
    en_in    = en;
    cs_in    = 1'b1;
    if (rdy_pulse) out_ready = 1'b1;
    step();
    if (rdy_pulse) out_ready = 1'b0;
    step();
    cs_in = 1'b0;
    repeat ($urandom_range(1, 4)) step();
  endtask

  task automatic window_const(input int unsigned v);
    repeat (WIN) frame(v, 1'b1, 1'b0);
  endtask

  task automatic chk_outs(input string tag, input int unsigned a, input int unsigned mn, input int unsigned mx);
    chk({tag, " avg"}, res_if.avg_data, a);
    chk({tag, " min"}, res_if.min_data, mn);
    chk({tag, " max"}, res_if.max_data, mx);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("reset out_valid", res_if.out_valid, 0);
    chk("reset overrun", res_if.overrun, 0);
    chk_outs("reset", 0, 0, 0);
    step();
    step();
    reset_n   = 1'b1;
    start     = 1'b1;
    out_ready = 1'b1;

    // Ramp 1..16.
    for (int i = 1; i <= WIN; i++) frame(i, 1'b1, 1'b0);
    chk_outs("ramp", 8, 1, 16);

    // Full-scale window must not wrap.
    window_const(16'hFFFF);
    chk_outs("fullscale", 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // Two windows with nobody taking the first.
    out_ready = 1'b0;
    window_const(100);
    window_const(200);
    chk("hold out_valid", res_if.out_valid, 1);
    chk("hold overrun", res_if.overrun, 1);
    chk_outs("hold", 100, 100, 100);
    out_ready = 1'b1;
    step();
    step();
    chk("drained out_valid", res_if.out_valid, 0);
    chk("sticky overrun", res_if.overrun, 1);
    chk("kept avg", res_if.avg_data, 100);
    start = 1'b0;
    step();
    step();
    chk("idle overrun", res_if.overrun, 0);
    chk_outs("idle", 0, 0, 0);
    start = 1'b1;

    // Second window completes in the very cycle the first is accepted.
    out_ready = 1'b0;
    window_const(50);
    repeat (WIN - 1) frame(60, 1'b1, 1'b0);
    frame(60, 1'b1, 1'b1);
    chk("sameclk out_valid", res_if.out_valid, 1);
    chk("sameclk overrun", res_if.overrun, 0);
    chk_outs("sameclk", 60, 60, 60);
    out_ready = 1'b1;
    step();

    // CS edges without en_in are ignored.
    repeat (5) frame(99, 1'b0, 1'b0);
    window_const(7);
    chk_outs("en gate", 7, 7, 7);

    // Start dropped mid-window discards the partial window.
    repeat (7) frame(3, 1'b1, 1'b0);
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    window_const(10);
    chk_outs("restart", 10, 10, 10);

    // Async reset mid-window while a result is held.
    out_ready = 1'b0;
    window_const(500);
    chk("pre-reset out_valid", res_if.out_valid, 1);
    repeat (5) frame(9, 1'b1, 1'b0);
    step();
    reset_n = 1'b0;
    #1;
    chk("async out_valid", res_if.out_valid, 0);
    chk_outs("async", 0, 0, 0);
    step();
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    window_const(10);
    chk_outs("post-reset", 10, 10, 10);

    // Random data with a randomly stalling consumer.
    rand_rdy = 1'b1;
    repeat (4 * WIN) frame($urandom_range(0, 16'hFFFF), 1'b1, 1'b0);
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("queue drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_win_avg.md
Name: adc_win_avg

Overview:
- Downstream consumer of the ADC serial front-end (real or imitator) outputs `CS`, `en` and `adc_data[15:0]`.
- Captures one sample per CS conversion frame while `en` is high.
- Over a window of 2^AVG_LOG2 samples it accumulates the sum, minimum and maximum.
- Presents average/min/max to the packetiser/host side through a valid/ready handshake, with a sticky overrun flag.

Parameters:
- DATA_W, 16, sample width; must match `adc_data` width.
- AVG_LOG2, 4, log2 of window length (window = 16 samples); legal range 1..8.

Ports:
- clk_100  in  1  system clock, 100 MHz, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  acquisition enable, the same signal that drives the front-end; low = synchronous clear.
- cs_in  in  1  front-end CS; a rising edge marks the current `adc_data` as a new sample.
- en_in  in  1  front-end data-valid level.
- adc_data  in  DATA_W  front-end sample, stable at and after the CS rising edge.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result when high together with `out_valid`.
- avg_data  out  DATA_W  window sum >> AVG_LOG2 (truncating).
- min_data  out  DATA_W  smallest sample in the window (unsigned).
- max_data  out  DATA_W  largest sample in the window (unsigned).
- overrun  out  1  sticky: a completed window was dropped because the previous result was not taken.

Behaviour:
- Reset (reset_n=0, async): `out_valid`, `avg_data`, `min_data`, `max_data`, `overrun` = 0; internal state as for the start-low clear below.
- Internal state:
  - cs_d: registered `cs_in`.
  - win_cnt: AVG_LOG2 bits.
  - acc: DATA_W+AVG_LOG2 bits, so it can never overflow.
  - cur_min: reset value all-ones.
  - cur_max: reset value 0.
- Sample strobe `smp` = `start` & `en_in` & `cs_in` & ~cs_d. It is combinational in the cycle `cs_in` is first seen high; the sample is captured on that clock edge.
  - A CS rise with `en_in`=0 or `start`=0 is ignored.
  - cs_d still tracks `cs_in`, so no strobe fires later.
- States:
  - IDLE: `start`=0. Everything is synchronously cleared: win_cnt=0, acc=0, cur_min=all-ones, cur_max=0, `out_valid`=0, `overrun`=0, outputs=0.
  - ACC: `start`=1. IDLE->ACC when `start` rises; ACC->IDLE when `start` falls.
- On `smp` with win_cnt < 2^AVG_LOG2-1:
  - acc += adc_data; cur_min = min(cur_min, adc_data); cur_max = max(cur_max, adc_data); win_cnt += 1.
- On `smp` with win_cnt = 2^AVG_LOG2-1 (window complete):
  - Result computed including this sample: avg = (acc+adc_data)>>AVG_LOG2, plus the final min/max.
  - acc, cur_min, cur_max and win_cnt return to their clear values, so the next window starts clean with no sample lost.
- Result load at window completion:
  - If `out_valid`=0, or `out_valid`&`out_ready` in the same cycle: load `avg_data`/`min_data`/`max_data`; `out_valid`=1 from the next cycle. Latency is 1 clock from the strobe cycle.
  - Else: the result is dropped, `overrun`<=1, and the held outputs stay unchanged.
- Handshake:
  - Once `out_valid` is high, the outputs are stable until accepted.
  - `out_valid`&`out_ready` without a completing window clears `out_valid` next cycle; the data outputs keep their last value.
  - `overrun` clears only via reset or `start`=0.
- Rates: at most one strobe per 2 clocks by construction; the front-end frame is about 19 clocks.
- Reset or `start` fall mid-window discards the partial window; the next window needs a full 2^AVG_LOG2 samples.

Decomposition:
- Shared package `adc_pkg`: ADC_DATA_W=16, DEFAULT_AVG_LOG2=4, and the min/max clear constants (ADC_MIN_INIT = all-ones, ADC_MAX_INIT = 0).
- One natural sub-module, `adc_win_stats`. It is the pure datapath: acc/min/max registers with `clr`, `add`, `sample` inputs and combinational next-result outputs.
- `adc_win_avg` keeps edge detection, win_cnt, the state control and the output handshake register.

Test Plan:
- Samples 1..16 at AVG_LOG2=4, `out_ready`=1 -> one `out_valid` pulse 1 clk after the 16th strobe; avg=8 (136>>4), min=1, max=16, overrun=0.
- Sixteen samples of 0xFFFF -> avg=0xFFFF, min=max=0xFFFF; no accumulator wrap.
- `out_ready`=0 across two full windows (window 1: all 100, window 2: all 200) -> outputs hold avg=100, overrun=1. Then `out_ready`=1 -> `out_valid` drops next cycle; overrun stays 1 until `start`=0.
- Window 2 completes in the same cycle `out_ready`=1 accepts window 1 -> window 2 result loaded, `out_valid` stays 1 continuously, overrun=0.
- CS rising edges with `en_in`=0 (5 edges), then 16 valid samples of value 7 -> only the 16 counted, avg=7.
- `start` dropped after sample 7, raised again, samples 10×16; separately, reset_n pulsed low mid-window -> outputs 0 immediately (async), first result avg=10, min=max=10.
